// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and helpers for the iterative multiply/divide sequencer.
// Operation encoding matches the controller's op field.
package muldivPkg;

    typedef enum logic [1:0] {
        UMUL = 2'd0,
        SMUL = 2'd1,
        UDIV = 2'd2,
        SDIV = 2'd3
    } ops;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } states;

    function automatic logic isSigned(input ops op);
        return (op == SMUL) || (op == SDIV);
    endfunction

    function automatic logic isDiv(input ops op);
        return (op == UDIV) || (op == SDIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the
// {acc, shift} register pair. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shift,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shift_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, opnd};
        rem        = {acc, shift[WIDTH-1]};
        // A successful subtract always leaves a value below 2^WIDTH.
        diff       = rem[WIDTH-1:0] - opnd;
        acc_next   = acc;
        shift_next = shift;
        if (is_div) begin
            if (rem >= {1'b0, opnd}) begin
                acc_next   = diff;
                shift_next = {shift[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = rem[WIDTH-1:0];
                shift_next = {shift[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shift[0]) begin
                acc_next   = sum[WIDTH:1];
                shift_next = {sum[0], shift[WIDTH-1:1]};
            end else begin
                acc_next   = {1'b0, acc[WIDTH-1:1]};
                shift_next = {acc[0], shift[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for signed/unsigned multiply and divide. Owns the FSM,
// iteration counter, sign fixup and result registers; stalls the pipeline while busy.
module muldiv_sequencer
    import muldivPkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi,
    output logic             divByZero
);

    localparam int CNT_W = $clog2(WIDTH);

    states            state_q, state_d;
    ops               op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   step_acc, step_shift;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic               op_div;

    assign op_div = isDiv(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (op_div),
        .acc        (acc_q),
        .shift      (shift_q),
        .opnd       (opnd_q),
        .acc_next   (step_acc),
        .shift_next (step_shift)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divide-by-zero passes through FIXUP untouched so its latency is three cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !flush) state_d = PREP;
            PREP:    if (flush) state_d = IDLE;
                     else if (op_div && (b_abs == '0)) state_d = FIXUP;
                     else state_d = ITER;
            ITER:    if (flush) state_d = IDLE;
                     else if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
            FIXUP:   state_d = flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        stall = busy || (start && (state_q == IDLE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= UMUL;
            a_q        <= '0;
            b_q        <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            acc_q      <= '0;
            shift_q    <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            dbz_pend_q <= dbz_pend_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            dbz_q      <= dbz_d;
        end
    end

    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        acc_d      = acc_q;
        shift_d    = shift_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        dbz_pend_d = dbz_pend_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        dbz_d      = dbz_q;

        // The most negative value maps onto its unsigned magnitude.
        a_abs    = (isSigned(op_q) && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
        b_abs    = (isSigned(op_q) && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
        prod     = {acc_q, shift_q};
        prod_neg = ~prod + 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d = ops'(op);
                    a_d  = operandA;
                    b_d  = operandB;
                end
            end
            PREP: begin
                sign_a_d   = isSigned(op_q) && a_q[WIDTH-1];
                sign_b_d   = isSigned(op_q) && b_q[WIDTH-1];
                acc_d      = '0;
                shift_d    = op_div ? a_abs : b_abs;
                opnd_d     = op_div ? b_abs : a_abs;
                cnt_d      = '0;
                dbz_pend_d = op_div && (b_abs == '0);
            end
            ITER: begin
                acc_d   = step_acc;
                shift_d = step_shift;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            FIXUP: begin
                if (!flush) begin
                    dbz_d = dbz_pend_q;
                    if (dbz_pend_q) begin
                        res_lo_d = '1;
                        res_hi_d = a_q;
                    end else if (op_div) begin
                        res_lo_d = (sign_a_q ^ sign_b_q) ? (~shift_q + 1'b1) : shift_q;
                        res_hi_d = sign_a_q ? (~acc_q + 1'b1) : acc_q;
                    end else if (sign_a_q ^ sign_b_q) begin
                        res_lo_d = prod_neg[WIDTH-1:0];
                        res_hi_d = prod_neg[2*WIDTH-1:WIDTH];
                    end else begin
                        res_lo_d = prod[WIDTH-1:0];
                        res_hi_d = prod[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    assign resultLo  = res_lo_q;
    assign resultHi  = res_hi_q;
    assign divByZero = dbz_q;

endmodule
